// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for a synchronous-read instruction memory.
// It drives the word address, remembers which PC the returning word belongs
// to, replays the word on stall, squashes on redirect and latches a sticky
// fault on bad redirect targets.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 1024,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic        VALID_OUT,
  output logic [31:0] INSTR_OUT,
  output logic [31:0] PC_OUT,
  output logic        FETCH_FAULT,
  output logic [31:0] FAULT_PC,
  output logic [31:0] FETCH_COUNT
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] resp_pc;
  logic        resp_valid;
  logic [31:0] fault_pc;
  logic [31:0] fetch_count;

  logic        bad_target;
  logic        valid;
  logic [31:0] next_addr;

  // Redirect target is unusable if misaligned or beyond the memory.
  always_comb begin
    bad_target = REDIRECT &&
                 ((REDIRECT_PC[1:0] != 2'b00) || (REDIRECT_PC >= ADDR_LIMIT));
  end

  // Word on the memory output is real unless squashed by a redirect.
  always_comb begin
    valid = (state == RUN) && resp_valid && !REDIRECT;
  end

  // Address presented to the memory this cycle.
  always_comb begin
    next_addr = RESET_PC;
    case (state)
      BOOT: next_addr = RESET_PC;
      RUN: begin
        if (REDIRECT) begin
          next_addr = bad_target ? resp_pc : REDIRECT_PC;
        end else if (STALL && valid) begin
          next_addr = resp_pc;
        end else begin
          next_addr = resp_pc + 32'd4;
        end
      end
      FAULT:   next_addr = fault_pc & ~32'h3;
      default: next_addr = RESET_PC;
    endcase
  end

  // Fetch state machine: boot, stream, or park on a bad target.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= BOOT;
      resp_pc    <= 32'h0;
      resp_valid <= 1'b0;
      fault_pc   <= 32'h0;
    end else begin
      case (state)
        BOOT: begin
          resp_pc    <= RESET_PC;
          resp_valid <= 1'b1;
          state      <= RUN;
        end
        RUN: begin
          if (bad_target) begin
            fault_pc   <= REDIRECT_PC;
            resp_valid <= 1'b0;
            state      <= FAULT;
          end else begin
            resp_pc    <= next_addr;
            resp_valid <= 1'b1;
          end
        end
        FAULT: begin
          resp_valid <= 1'b0;
        end
        default: begin
          state      <= BOOT;
          resp_valid <= 1'b0;
        end
      endcase
    end
  end

  // Count instructions accepted by the IF/ID register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      fetch_count <= 32'h0;
    end else if (valid && !STALL) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end

  // Output drive; squashed cycles present a NOP at PC 0.
  always_comb begin
    IMEM_ADDR   = next_addr;
    VALID_OUT   = valid;
    PC_OUT      = valid ? resp_pc : 32'h0;
    INSTR_OUT   = valid ? IMEM_DATA : NOP;
    FETCH_FAULT = (state == FAULT);
    FAULT_PC    = fault_pc;
    FETCH_COUNT = fetch_count;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Sequences the synchronous-read instruction memory for the IF stage.
- Generates the word address each cycle, tracks which PC the returning word belongs to, and replays the read on downstream stall.
- Squashes the in-flight word on a branch/jump redirect and raises a sticky fault on misaligned or out-of-range fetch targets.
- Sits between the PC/branch logic in EX and the instruction memory; its outputs feed the IF/ID pipeline register.

Parameters:
- RESET_PC, 32'h00000000, first fetch address after reset.
- DEPTH, 1024, instruction memory depth in 32-bit words; legal byte addresses are 0 .. 4*DEPTH-4.
- NOP, 32'h00000013, instruction driven on INSTR_OUT whenever VALID_OUT=0 (addi x0,x0,0).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RESET  in  1  asynchronous, active-high reset; also tied to the memory's reset.
- IMEM_ADDR  out  32  byte address to memory; combinational from state and inputs, sampled by memory on the rising edge.
- IMEM_DATA  in  32  registered memory read data; holds the word for the address sampled at the previous edge.
- STALL  in  1  downstream not ready; current output must be held.
- REDIRECT  in  1  taken branch/jump; flush and refetch.
- REDIRECT_PC  in  32  redirect target byte address.
- VALID_OUT  out  1  INSTR_OUT/PC_OUT carry a real instruction this cycle.
- INSTR_OUT  out  32  fetched instruction.
- PC_OUT  out  32  byte address of INSTR_OUT.
- FETCH_FAULT  out  1  sticky; set on bad redirect target.
- FAULT_PC  out  32  offending target; 0 until a fault occurs.
- FETCH_COUNT  out  32  count of accepted instructions (VALID_OUT=1 and STALL=0); wraps at 2^32.

Behaviour:
- States: BOOT, RUN, FAULT.
- Registers: state, resp_pc (address sampled by memory at the last edge), resp_valid, FAULT_PC, FETCH_COUNT.
- Reset (async, while RESET=1):
  - state=BOOT, resp_valid=0, resp_pc=0, FAULT_PC=0, FETCH_COUNT=0, FETCH_FAULT=0.
  - VALID_OUT=0, INSTR_OUT=NOP, PC_OUT=0, IMEM_ADDR=RESET_PC.
  - Memory data during reset is ignored.
- BOOT:
  - IMEM_ADDR=RESET_PC, VALID_OUT=0.
  - Next edge: resp_pc<=RESET_PC, resp_valid<=1, state<=RUN.
  - STALL and REDIRECT are ignored in BOOT.
- RUN outputs:
  - VALID_OUT = resp_valid & !REDIRECT.
  - PC_OUT = VALID_OUT ? resp_pc : 0.
  - INSTR_OUT = VALID_OUT ? IMEM_DATA : NOP.
- RUN IMEM_ADDR priority:
  1. REDIRECT=1: IMEM_ADDR=REDIRECT_PC.
  2. STALL=1 and VALID_OUT=1: IMEM_ADDR=resp_pc (replay the same word).
  3. Otherwise: IMEM_ADDR=resp_pc+4 (32-bit add, wraps).
- RUN edge update: resp_pc<=IMEM_ADDR, resp_valid<=1.
- Latency:
  - Redirect asserted in cycle t gives valid output of the target in cycle t+1.
  - First valid output is the second cycle after reset release.
  - Sustained throughput is 1 instruction/cycle.
- STALL with VALID_OUT=0 has no effect.
- REDIRECT and STALL in the same cycle: REDIRECT wins; the held instruction is discarded.
- Bad target: REDIRECT=1 with REDIRECT_PC[1:0]!=0 or REDIRECT_PC>=4*DEPTH:
  - IMEM_ADDR=resp_pc (harmless), VALID_OUT=0.
  - Next edge: FAULT_PC<=REDIRECT_PC, state<=FAULT.
- Sequential wrap (resp_pc+4 reaching 4*DEPTH) is not a fault; the memory index wraps naturally.
- FAULT:
  - FETCH_FAULT=1, VALID_OUT=0, IMEM_ADDR=FAULT_PC & ~3, resp_valid<=0.
  - All inputs ignored; exit only via RESET.
- FETCH_COUNT increments on each cycle with VALID_OUT=1 and STALL=0.
- RESET asserted mid-stream:
  - All state clears immediately and the in-flight word is dropped.
  - Fetch restarts at RESET_PC via BOOT.

Test Plan:
- Reset release, no stall, memory preloaded word i = 32'hA000_0000+i -> cycle 2 after release: VALID_OUT=1, PC_OUT=0, INSTR_OUT=A0000000; then PC_OUT=4, 8, 12 on consecutive cycles; FETCH_COUNT=3 after the third.
- STALL held 3 cycles while PC_OUT=8 -> IMEM_ADDR=8 on each stalled cycle; outputs hold 8/A0000002; after release next is PC 12; FETCH_COUNT counts the held instruction once.
- REDIRECT with REDIRECT_PC=0x100 while PC_OUT=0x10 -> VALID_OUT=0 that cycle; next cycle PC_OUT=0x100, INSTR_OUT=A0000040; PC 0x14 never appears.
- REDIRECT and STALL together with REDIRECT_PC=0x40 -> redirect taken; next valid PC_OUT=0x40.
- REDIRECT_PC=0x102 (misaligned), then separately REDIRECT_PC=0x1000 with DEPTH=1024 -> FETCH_FAULT=1, FAULT_PC=0x102 (respectively 0x1000); VALID_OUT stays 0 for 20 cycles of stimulus; RESET clears FETCH_FAULT and restarts at 0.
- RESET asserted asynchronously mid-cycle during streaming at PC 0x20 -> VALID_OUT drops and FETCH_COUNT=0 immediately; after release the first valid PC_OUT=0.
